// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the 16-bit mini-MIPS core.
//
// Owns the fetch PC and issues in-order word requests to instruction memory.
// It buffers returned words with their PCs in a DEPTH-entry queue and presents
// the head to decode.
//
// Handshakes (all ports): a transfer happens at a rising clock edge where both
// valid and ready are 1. A producer holding valid=1 keeps its payload stable
// until the transfer. The memory response port has no ready: a response is
// taken in the cycle it is valid. imem_req_valid is combinational on
// redirect_valid and reset. Everything else that leaves the block comes
// straight from registers.
//
// Credit scheme: a request may only issue while outstanding + count < DEPTH.
// Every response therefore has a queue slot waiting for it, and the memory
// response port never needs backpressure.
//
// Redirect: the queue and the pc FIFO are flushed. Responses for requests
// accepted before the redirect are counted in discard and dropped as they
// arrive. Memory returns responses in order, so the stale ones always arrive
// before any response to a request issued after the redirect.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [15:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
);

    // Pointer width (DEPTH is a power of two, so pointers wrap naturally).
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter width: holds 0..DEPTH inclusive.
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Width for the outstanding + count credit sum.
    localparam int unsigned SW = CW + 1;

    localparam logic [SW-1:0] DEPTH_S     = SW'(DEPTH);
    localparam logic [15:0]   RESET_PC_AL = {RESET_PC[15:1], 1'b0};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]   fetch_pc_q,    fetch_pc_d;
    logic [CW-1:0] count_q,       count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q,     discard_d;

    // Instruction queue: head at q_rd_ptr, tail at q_wr_ptr.
    logic [PW-1:0] q_rd_ptr_q, q_rd_ptr_d;
    logic [PW-1:0] q_wr_ptr_q, q_wr_ptr_d;
    logic [15:0]   q_instr_q [DEPTH];
    logic [15:0]   q_pc_q    [DEPTH];

    // PC FIFO: pcs of live (non-stale) requests in issue order. It is written
    // at issue and read when the matching response is pushed into the queue.
    logic [PW-1:0] pf_rd_ptr_q, pf_rd_ptr_d;
    logic [PW-1:0] pf_wr_ptr_q, pf_wr_ptr_d;
    logic [15:0]   pf_pc_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [SW-1:0] credit_used;
    logic          req_fire;
    logic          resp_take;
    logic          resp_drop;
    logic          resp_push;
    logic          pop;

    assign credit_used = SW'(outstanding_q) + SW'(count_q);

    // No request in reset, in a redirect cycle, or when every slot is spoken for.
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_S);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is spurious and ignored outright.
    assign resp_take = imem_resp_valid && (outstanding_q != '0);
    // Stale responses are dropped, and so is the one arriving in a redirect cycle.
    assign resp_drop = resp_take && ((discard_q != '0) || redirect_valid);
    assign resp_push = resp_take && !resp_drop;

    // Head presentation: read straight from the queue registers, zero when empty.
    assign ir_valid = (count_q != '0);
    assign ir       = ir_valid ? q_instr_q[q_rd_ptr_q] : 16'h0000;
    assign ir_pc    = ir_valid ? q_pc_q[q_rd_ptr_q]    : 16'h0000;
    assign pop      = ir_valid && ir_ready;

    // ------------------------------------------------------------------
    // Next-state logic for pc, counters and pointers
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        q_rd_ptr_d    = q_rd_ptr_q;
        q_wr_ptr_d    = q_wr_ptr_q;
        pf_rd_ptr_d   = pf_rd_ptr_q;
        pf_wr_ptr_d   = pf_wr_ptr_q;

        if (redirect_valid) begin
            // Flush everything buffered. Whatever is still in flight after
            // this cycle's response becomes stale. A head handshake in this
            // cycle has already been seen by decode and simply goes with the flush.
            fetch_pc_d    = {redirect_pc[15:1], 1'b0};
            count_d       = '0;
            q_rd_ptr_d    = '0;
            q_wr_ptr_d    = '0;
            pf_rd_ptr_d   = '0;
            pf_wr_ptr_d   = '0;
            outstanding_d = outstanding_q - CW'(resp_take);
            discard_d     = outstanding_q - CW'(resp_take);
        end else begin
            if (req_fire) begin
                fetch_pc_d  = fetch_pc_q + 16'd2;
                pf_wr_ptr_d = pf_wr_ptr_q + PW'(1);
            end

            outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_take);

            if (resp_drop) begin
                discard_d = discard_q - CW'(1);
            end

            if (resp_push) begin
                q_wr_ptr_d  = q_wr_ptr_q + PW'(1);
                pf_rd_ptr_d = pf_rd_ptr_q + PW'(1);
            end

            if (pop) begin
                q_rd_ptr_d = q_rd_ptr_q + PW'(1);
            end

            count_d = count_q + CW'(resp_push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Control state register with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC_AL;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            q_rd_ptr_q    <= '0;
            q_wr_ptr_q    <= '0;
            pf_rd_ptr_q   <= '0;
            pf_wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            q_rd_ptr_q    <= q_rd_ptr_d;
            q_wr_ptr_q    <= q_wr_ptr_d;
            pf_rd_ptr_q   <= pf_rd_ptr_d;
            pf_wr_ptr_q   <= pf_wr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Queue and pc FIFO storage writes. There is no reset: the contents are
    // only observed through count and the pointers, and those are reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset && req_fire) begin
            pf_pc_q[pf_wr_ptr_q] <= fetch_pc_q;
        end
        if (!reset && resp_push) begin
            q_instr_q[q_wr_ptr_q] <= imem_resp_data;
            q_pc_q[q_wr_ptr_q]    <= pf_pc_q[pf_rd_ptr_q];
        end
    end

endmodule
